// File: rtl/expr_eval_pkg.sv
// Shared definitions for the expression evaluator and its character classifier:
// state and pending-operator encodings, ASCII constants and the term multiply.
package expr_eval_pkg;

   typedef enum logic [1:0] {
      S_START = 2'd0,
      S_NUM   = 2'd1,
      S_OP    = 2'd2,
      S_ERR   = 2'd3
   } state_e;

   typedef enum logic {
      PEND_ADD = 1'b0,
      PEND_MUL = 1'b1
   } pend_e;

   localparam logic [7:0] CH_0    = 8'h30;
   localparam logic [7:0] CH_9    = 8'h39;
   localparam logic [7:0] CH_PLUS = 8'h2B;
   localparam logic [7:0] CH_MUL  = 8'h2A;
   localparam logic [7:0] CH_EQ   = 8'h3D;

   // 32x4 unsigned product, truncated to the 32-bit datapath (modulo 2^32).
   function automatic logic [31:0] mul32x4(input logic [31:0] a, input logic [3:0] b);
      return 32'({4'd0, a} * {32'd0, b});
   endfunction

endpackage

// File: rtl/expr_char_class.sv
// Character classifier: decodes one ASCII byte into digit/operator/terminator
// flags and the digit value (zero for non-digits).
module expr_char_class
   import expr_eval_pkg::*;
(
   input  logic [7:0] in_char,
   output logic       is_digit,
   output logic       is_plus,
   output logic       is_mul,
   output logic       is_eq,
   output logic [3:0] digit_val
);

   // ASCII '0'..'9' carry their value in the low nibble.
   always_comb begin
      is_digit = (in_char >= CH_0) && (in_char <= CH_9);
      is_plus  = (in_char == CH_PLUS);
      is_mul   = (in_char == CH_MUL);
      is_eq    = (in_char == CH_EQ);
      if (is_digit) begin
         digit_val = in_char[3:0];
      end else begin
         digit_val = 4'd0;
      end
   end

endmodule

// File: rtl/expr_eval.sv
// Streaming evaluator for single-digit '+'/'*' expressions terminated by '=',
// with '*' binding tighter than '+' and modulo-2^32 unsigned arithmetic.
module expr_eval
   import expr_eval_pkg::*;
(
   input  logic        clk,
   input  logic        clr,
   input  logic [7:0]  in,
   input  logic        in_valid,
   output logic        legal,
   output logic [31:0] value,
   output logic [31:0] result,
   output logic        done,
   output logic        err
);

   logic       is_digit_s;
   logic       is_plus_s;
   logic       is_mul_s;
   logic       is_eq_s;
   logic [3:0] digit_val_s;

   state_e      state_q,  state_d;
   pend_e       pend_q,   pend_d;
   logic [31:0] sum_q,    sum_d;
   logic [31:0] term_q,   term_d;
   logic [31:0] result_q, result_d;
   logic        done_q,   done_d;
   logic        err_q,    err_d;

   expr_char_class u_char_class (
      .in_char   (in),
      .is_digit  (is_digit_s),
      .is_plus   (is_plus_s),
      .is_mul    (is_mul_s),
      .is_eq     (is_eq_s),
      .digit_val (digit_val_s)
   );

   // Next-state logic: sum holds closed '+' terms, term holds the running product.
   always_comb begin
      state_d  = state_q;
      pend_d   = pend_q;
      sum_d    = sum_q;
      term_d   = term_q;
      result_d = result_q;
      done_d   = 1'b0;
      err_d    = 1'b0;
      if (in_valid) begin
         case (state_q)
            S_START: begin
               if (is_digit_s) begin
                  term_d  = {28'd0, digit_val_s};
                  sum_d   = 32'd0;
                  state_d = S_NUM;
               end else if (is_eq_s) begin
                  done_d  = 1'b1;
                  err_d   = 1'b1;
                  state_d = S_START;
               end else begin
                  state_d = S_START;
               end
            end
            S_NUM: begin
               if (is_plus_s) begin
                  sum_d   = sum_q + term_q;
                  pend_d  = PEND_ADD;
                  state_d = S_OP;
               end else if (is_mul_s) begin
                  pend_d  = PEND_MUL;
                  state_d = S_OP;
               end else if (is_eq_s) begin
                  result_d = sum_q + term_q;
                  done_d   = 1'b1;
                  err_d    = 1'b0;
                  sum_d    = 32'd0;
                  term_d   = 32'd0;
                  state_d  = S_START;
               end else begin
                  state_d = S_ERR;
               end
            end
            S_OP: begin
               if (is_digit_s) begin
                  if (pend_q == PEND_MUL) begin
                     term_d = mul32x4(term_q, digit_val_s);
                  end else begin
                     term_d = {28'd0, digit_val_s};
                  end
                  state_d = S_NUM;
               end else if (is_eq_s) begin
                  done_d  = 1'b1;
                  err_d   = 1'b1;
                  state_d = S_START;
               end else begin
                  state_d = S_ERR;
               end
            end
            S_ERR: begin
               if (is_eq_s) begin
                  done_d  = 1'b1;
                  err_d   = 1'b1;
                  state_d = S_START;
               end else begin
                  state_d = S_ERR;
               end
            end
            default: begin
               state_d = S_START;
            end
         endcase
      end else begin
         state_d = state_q;
      end
   end

   // State and output registers; clr discards any partial expression at once.
   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         state_q  <= S_START;
         pend_q   <= PEND_ADD;
         sum_q    <= 32'd0;
         term_q   <= 32'd0;
         result_q <= 32'd0;
         done_q   <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         pend_q   <= pend_d;
         sum_q    <= sum_d;
         term_q   <= term_d;
         result_q <= result_d;
         done_q   <= done_d;
         err_q    <= err_d;
      end
   end

   assign legal  = (state_q == S_NUM);
   assign value  = sum_q + term_q;
   assign result = result_q;
   assign done   = done_q;
   assign err    = err_q;

endmodule

// File: tb/tb_expr_eval.sv
// Self-checking bench for expr_eval: directed expressions plus a random
// character stream, compared against a token-queue reference model.
module tb_expr_eval;

   logic        clk;
   logic        clr;
   logic [7:0]  in_ch;
   logic        in_valid;
   logic        legal;
   logic [31:0] value;
   logic [31:0] result;
   logic        done;
   logic        err;

   int n_checks;
   int n_errors;

   // Reference model: characters of the expression currently being entered.
   byte unsigned expr_q[$];
   logic        exp_legal;
   logic [31:0] exp_value;
   logic [31:0] exp_result;
   logic        exp_done;
   logic        exp_err;

   expr_eval dut (
      .clk      (clk),
      .clr      (clr),
      .in       (in_ch),
      .in_valid (in_valid),
      .legal    (legal),
      .value    (value),
      .result   (result),
      .done     (done),
      .err      (err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic bit is_dig(input byte unsigned c);
      return (c >= 8'h30) && (c <= 8'h39);
   endfunction

   // Well-formed means digit (op digit)* with no trailing operator.
   function automatic bit well_formed();
      if (expr_q.size() % 2 == 0) return 1'b0;
      for (int i = 0; i < expr_q.size(); i++) begin
         if (i % 2 == 0) begin
            if (!is_dig(expr_q[i])) return 1'b0;
         end else if (expr_q[i] != 8'h2B && expr_q[i] != 8'h2A) begin
            return 1'b0;
         end
      end
      return 1'b1;
   endfunction

   // Sum of products, each product restarted after a '+'.
   function automatic logic [31:0] eval_expr();
      logic [31:0] sum;
      logic [31:0] prod;
      logic [31:0] d;
      sum  = 32'd0;
      prod = 32'd0;
      for (int i = 0; i < expr_q.size(); i += 2) begin
         d = 32'(expr_q[i]) - 32'd48;
         if (i == 0 || expr_q[i-1] == 8'h2B) begin
            sum  = sum + prod;
            prod = d;
         end else begin
            prod = prod * d;
         end
      end
      return sum + prod;
   endfunction

   task automatic model_reset();
      expr_q.delete();
      exp_result = 32'd0;
      exp_legal  = 1'b0;
      exp_value  = 32'd0;
      exp_done   = 1'b0;
      exp_err    = 1'b0;
   endtask

   // Present one character for one clock, then update the model expectations.
   task automatic drive_char(input logic [7:0] c, input logic v);
      @(negedge clk);
      in_ch    = c;
      in_valid = v;
      @(posedge clk);
      #1;
      exp_done = 1'b0;
      exp_err  = 1'b0;
      if (v) begin
         if (c == 8'h3D) begin
            exp_done = 1'b1;
            exp_err  = !well_formed();
            if (!exp_err) exp_result = eval_expr();
            expr_q.delete();
         end else if (expr_q.size() != 0 || is_dig(c)) begin
            expr_q.push_back(c);
         end
      end
      exp_legal = well_formed();
      exp_value = exp_legal ? eval_expr() : 32'd0;
      in_valid  = 1'b0;
   endtask

   task automatic test_reset();
      clr      = 1'b1;
      in_valid = 1'b0;
      in_ch    = 8'h00;
      model_reset();
      repeat (3) @(posedge clk);
      #1;
      n_checks++;
      if ({legal, value, result, done, err} !== {1'b0, 32'd0, 32'd0, 1'b0, 1'b0}) begin
         n_errors++;
         $display("FAIL reset: got legal=%0b value=%0d result=%0d done=%0b err=%0b, expected all zero",
                  legal, value, result, done, err);
      end
      @(negedge clk);
      clr = 1'b0;
   endtask

   task automatic test_precedence();
      string s;
      s = "1+2*3=";
      for (int i = 0; i < s.len(); i++) begin
         drive_char(s[i], 1'b1);
         n_checks++;
         if (legal !== exp_legal || done !== exp_done || err !== exp_err || result !== exp_result ||
             (exp_legal && value !== exp_value)) begin
            n_errors++;
            $display("FAIL prec[%0d]: got l=%0b v=%0d d=%0b e=%0b r=%0d, expected l=%0b v=%0d d=%0b e=%0b r=%0d",
                     i, legal, value, done, err, result, exp_legal, exp_value, exp_done, exp_err, exp_result);
         end
      end
      n_checks++;
      if (result !== 32'd7 || err !== 1'b0 || done !== 1'b1) begin
         n_errors++;
         $display("FAIL prec_result: got result=%0d err=%0b done=%0b, expected 7 0 1", result, err, done);
      end
   endtask

   task automatic test_chain();
      string s;
      s = "2*3*4+5=";
      for (int i = 0; i < s.len(); i++) begin
         drive_char(s[i], 1'b1);
         n_checks++;
         if (legal !== exp_legal || done !== exp_done || err !== exp_err || result !== exp_result ||
             (exp_legal && value !== exp_value)) begin
            n_errors++;
            $display("FAIL chain[%0d]: got l=%0b v=%0d d=%0b e=%0b r=%0d, expected l=%0b v=%0d d=%0b e=%0b r=%0d",
                     i, legal, value, done, err, result, exp_legal, exp_value, exp_done, exp_err, exp_result);
         end
         if (i == 4) begin
            n_checks++;
            if (value !== 32'd24 || legal !== 1'b1) begin
               n_errors++;
               $display("FAIL chain_value: got value=%0d legal=%0b, expected 24 1", value, legal);
            end
         end
      end
      n_checks++;
      if (result !== 32'd29 || err !== 1'b0) begin
         n_errors++;
         $display("FAIL chain_result: got result=%0d err=%0b, expected 29 0", result, err);
      end
   endtask

   task automatic test_junk_and_error();
      string s;
      s = "ab3=1+*4=";
      for (int i = 0; i < s.len(); i++) begin
         drive_char(s[i], 1'b1);
         n_checks++;
         if (legal !== exp_legal || done !== exp_done || err !== exp_err || result !== exp_result ||
             (exp_legal && value !== exp_value)) begin
            n_errors++;
            $display("FAIL junkerr[%0d]: got l=%0b v=%0d d=%0b e=%0b r=%0d, expected l=%0b v=%0d d=%0b e=%0b r=%0d",
                     i, legal, value, done, err, result, exp_legal, exp_value, exp_done, exp_err, exp_result);
         end
         if (i == 3) begin
            n_checks++;
            if (result !== 32'd3 || err !== 1'b0 || done !== 1'b1) begin
               n_errors++;
               $display("FAIL junk_result: got result=%0d err=%0b done=%0b, expected 3 0 1", result, err, done);
            end
         end
      end
      n_checks++;
      if (result !== 32'd3 || err !== 1'b1 || done !== 1'b1) begin
         n_errors++;
         $display("FAIL error_result: got result=%0d err=%0b done=%0b, expected 3 1 1", result, err, done);
      end
   endtask

   task automatic test_nines();
      for (int i = 0; i < 22; i++) begin
         drive_char((i == 21) ? 8'h3D : ((i % 2 == 0) ? 8'h39 : 8'h2A), 1'b1);
         n_checks++;
         if (legal !== exp_legal || done !== exp_done || err !== exp_err || result !== exp_result ||
             (exp_legal && value !== exp_value)) begin
            n_errors++;
            $display("FAIL nines[%0d]: got l=%0b v=%0d d=%0b e=%0b r=%0d, expected l=%0b v=%0d d=%0b e=%0b r=%0d",
                     i, legal, value, done, err, result, exp_legal, exp_value, exp_done, exp_err, exp_result);
         end
      end
      n_checks++;
      if (result !== 32'd1316288537 || err !== 1'b0) begin
         n_errors++;
         $display("FAIL nines_result: got result=%0d err=%0b, expected 1316288537 0", result, err);
      end
   endtask

   task automatic test_clr_and_gaps();
      string s;
      s = "5+6";
      for (int i = 0; i < s.len(); i++) drive_char(s[i], 1'b1);
      @(negedge clk);
      #2;
      clr      = 1'b1;
      in_ch    = 8'h3D;
      in_valid = 1'b1;
      model_reset();
      #1;
      n_checks++;
      if ({legal, value, result, done, err} !== {1'b0, 32'd0, 32'd0, 1'b0, 1'b0}) begin
         n_errors++;
         $display("FAIL clr_async: got legal=%0b value=%0d result=%0d done=%0b err=%0b, expected all zero",
                  legal, value, result, done, err);
      end
      @(posedge clk);
      #1;
      n_checks++;
      if ({legal, value, result, done, err} !== {1'b0, 32'd0, 32'd0, 1'b0, 1'b0}) begin
         n_errors++;
         $display("FAIL clr_hold: got legal=%0b value=%0d result=%0d done=%0b err=%0b, expected all zero",
                  legal, value, result, done, err);
      end
      @(negedge clk);
      clr      = 1'b0;
      in_valid = 1'b0;
      s = "7++=";
      for (int i = 0; i < s.len(); i++) begin
         drive_char(s[i], (i == 0 || i == 3));
         n_checks++;
         if (legal !== exp_legal || done !== exp_done || err !== exp_err || result !== exp_result ||
             (exp_legal && value !== exp_value)) begin
            n_errors++;
            $display("FAIL clrgap[%0d]: got l=%0b v=%0d d=%0b e=%0b r=%0d, expected l=%0b v=%0d d=%0b e=%0b r=%0d",
                     i, legal, value, done, err, result, exp_legal, exp_value, exp_done, exp_err, exp_result);
         end
      end
      drive_char(8'h3D, 1'b0);
      n_checks++;
      if (result !== 32'd7 || done !== 1'b0 || legal !== 1'b0) begin
         n_errors++;
         $display("FAIL clr_result: got result=%0d done=%0b legal=%0b, expected 7 0 0", result, done, legal);
      end
   endtask

   task automatic test_random();
      byte unsigned alpha[16];
      logic [7:0]   c;
      logic         v;
      alpha = '{8'h30, 8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37,
                8'h38, 8'h39, 8'h2B, 8'h2A, 8'h3D, 8'h2B, 8'h2A, 8'h61};
      for (int i = 0; i < 600; i++) begin
         c = alpha[$urandom_range(0, 15)];
         v = ($urandom_range(0, 4) != 0);
         drive_char(c, v);
         n_checks++;
         if (legal !== exp_legal || done !== exp_done || err !== exp_err || result !== exp_result ||
             (exp_legal && value !== exp_value)) begin
            n_errors++;
            $display("FAIL random[%0d] c=%0h v=%0b: got l=%0b v=%0d d=%0b e=%0b r=%0d, expected l=%0b v=%0d d=%0b e=%0b r=%0d",
                     i, c, v, legal, value, done, err, result, exp_legal, exp_value, exp_done, exp_err, exp_result);
         end
      end
   endtask

   task automatic test_back_to_back();
      string s;
      s = "==3=4*5=12+3=9+=";
      for (int i = 0; i < s.len(); i++) begin
         drive_char(s[i], 1'b1);
         n_checks++;
         if (legal !== exp_legal || done !== exp_done || err !== exp_err || result !== exp_result ||
             (exp_legal && value !== exp_value)) begin
            n_errors++;
            $display("FAIL b2b[%0d]: got l=%0b v=%0d d=%0b e=%0b r=%0d, expected l=%0b v=%0d d=%0b e=%0b r=%0d",
                     i, legal, value, done, err, result, exp_legal, exp_value, exp_done, exp_err, exp_result);
         end
      end
      n_checks++;
      if (result !== 32'd20 || err !== 1'b1) begin
         n_errors++;
         $display("FAIL b2b_result: got result=%0d err=%0b, expected 20 1", result, err);
      end
   endtask

   initial begin
      n_checks = 0;
      n_errors = 0;
      test_reset();
      test_precedence();
      test_chain();
      test_junk_and_error();
      test_nines();
      test_clr_and_gaps();
      test_back_to_back();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
